iir_deemph: RTL and testbench

- Fixed-point first-order IIR de-emphasis filter for the FM receive chain.
- Sits directly upstream of the gain stage: reads demodulated audio from an input FIFO and writes filtered samples to the FIFO that feeds gain.
- Implements y[n] = DQ(X0*x[n]) + DQ(X1*x[n-1]) - DQ(Y1*y[n-1]). It uses one shared multiplier, with the three products computed over three cycles.
- Same FIFO-side handshake as gain, so it chains through standard fifo instances in a top wrapper.

---
 rtl/iir_deemph_pkg.sv | 29 ++
 rtl/fifo.sv | 47 ++++
 rtl/iir_deemph_top.sv | 56 +++++
 rtl/iir_deemph.sv | 103 ++++++++++
 tb/tb_iir_deemph.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_deemph_pkg.sv
// Shared fixed-point helpers and default de-emphasis coefficients for the FM receive chain.
// Coefficients are derived from the pre-warped corner W_PP and quantized with BITS fraction bits.
package iir_deemph_pkg;

    localparam int  QBITS = 10;
    localparam int  DQ_W  = 128;
    localparam real W_PP  = 0.21140067;

    function automatic int QUANTIZE_F(input real f, input int bits);
        return $rtoi(f * $itor(1 << bits));
    endfunction

    function automatic int QUANTIZE_I(input int i, input int bits);
        return i <<< bits;
    endfunction

    // Divide by 2^bits rounding toward zero, so small negative products collapse to 0 rather than -1.
    function automatic logic signed [DQ_W-1:0] DEQUANTIZE(input logic signed [DQ_W-1:0] p,
                                                          input int bits);
        logic signed [DQ_W-1:0] bias;
        bias = p[DQ_W-1] ? $signed((DQ_W'(1) << bits) - DQ_W'(1)) : '0;
        return (p + bias) >>> bits;
    endfunction

    localparam int IIR_X0 = QUANTIZE_F(W_PP / (1.0 + W_PP), QBITS);
    localparam int IIR_X1 = QUANTIZE_F(W_PP / (1.0 + W_PP), QBITS);
    localparam int IIR_Y1 = QUANTIZE_F((W_PP - 1.0) / (W_PP + 1.0), QBITS);

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; dout presents the oldest entry whenever empty is low.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/iir_deemph_top.sv
// Receive-chain slice: input FIFO -> de-emphasis filter -> output FIFO feeding the gain stage.
module iir_deemph_top #(
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_wr_en,
    input  logic [DATA_SIZE-1:0] in_din,
    output logic                 in_full,
    input  logic                 out_rd_en,
    output logic [DATA_SIZE-1:0] out_dout,
    output logic                 out_empty
);

    logic                 filt_rd_en;
    logic                 filt_empty;
    logic [DATA_SIZE-1:0] filt_din;
    logic                 filt_wr_en;
    logic                 filt_full;
    logic [DATA_SIZE-1:0] filt_dout;

    fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (in_wr_en),
        .din   (in_din),
        .full  (in_full),
        .rd_en (filt_rd_en),
        .dout  (filt_din),
        .empty (filt_empty)
    );

    iir_deemph #(.DATA_SIZE(DATA_SIZE)) u_iir (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (filt_rd_en),
        .in_empty  (filt_empty),
        .din       (filt_din),
        .out_wr_en (filt_wr_en),
        .out_full  (filt_full),
        .dout      (filt_dout)
    );

    fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (filt_wr_en),
        .din   (filt_dout),
        .full  (filt_full),
        .rd_en (out_rd_en),
        .dout  (out_dout),
        .empty (out_empty)
    );

endmodule

// File: rtl/iir_deemph.sv
// First-order fixed-point IIR de-emphasis filter between two show-ahead FIFOs.
// One shared multiplier walks the three taps per sample; history advances only on a push.
module iir_deemph
    import iir_deemph_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int BITS      = QBITS,
    parameter int X0        = IIR_X0,
    parameter int X1        = IIR_X1,
    parameter int Y1        = IIR_Y1
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 in_rd_en,
    input  logic                 in_empty,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic [DATA_SIZE-1:0] dout
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE} state_t;

    localparam logic [DATA_SIZE-1:0] C_X0 = DATA_SIZE'(X0);
    localparam logic [DATA_SIZE-1:0] C_X1 = DATA_SIZE'(X1);
    localparam logic [DATA_SIZE-1:0] C_Y1 = DATA_SIZE'(Y1);

    state_t                 state;
    logic [1:0]             tap;
    logic [DATA_SIZE-1:0]   x_cur;
    logic [DATA_SIZE-1:0]   x_prev;
    logic [DATA_SIZE-1:0]   y_prev;
    logic [DATA_SIZE-1:0]   acc;
    logic [DATA_SIZE-1:0]   coef;
    logic [DATA_SIZE-1:0]   operand;
    logic [DATA_SIZE-1:0]   term;
    logic [DATA_SIZE-1:0]   acc_next;
    logic [2*DATA_SIZE-1:0] product;

    assign in_rd_en  = reset && (state == S_IDLE) && !in_empty;
    assign out_wr_en = reset && (state == S_WRITE) && !out_full;

    // Sign-extended operands keep the low 2*DATA_SIZE bits equal to the signed product.
    always_comb begin
        coef    = C_X0;
        operand = x_cur;
        case (tap)
            2'd1: begin
                coef    = C_X1;
                operand = x_prev;
            end
            2'd2: begin
                coef    = C_Y1;
                operand = y_prev;
            end
            default: ;
        endcase
        product  = {{DATA_SIZE{coef[DATA_SIZE-1]}}, coef}
                 * {{DATA_SIZE{operand[DATA_SIZE-1]}}, operand};
        term     = DATA_SIZE'(DEQUANTIZE(DQ_W'($signed(product)), BITS));
        acc_next = (tap == 2'd2) ? acc - term : acc + term;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            tap    <= '0;
            x_cur  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            acc    <= '0;
            dout   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!in_empty) begin
                        x_cur <= din;
                        acc   <= '0;
                        tap   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    tap <= tap + 2'd1;
                    if (tap == 2'd2) begin
                        dout  <= acc_next;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!out_full) begin
                        x_prev <= x_cur;
                        y_prev <= dout;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_deemph.sv
// Scoreboard bench for iir_deemph: FIFO-side driver and monitor around an integer reference IIR.
// Directed vectors use literal expectations; random streams use the reference model.
module tb_iir_deemph;

    localparam int DATA_SIZE = 32;
    localparam int BITS      = 10;
    localparam int X0        = 178;
    localparam int X1        = 178;
    localparam int Y1        = -666;

    logic                 clock     = 1'b0;
    logic                 reset     = 1'b0;
    logic                 in_empty  = 1'b1;
    logic                 out_full  = 1'b0;
    logic [DATA_SIZE-1:0] din       = '0;
    logic                 in_rd_en;
    logic                 out_wr_en;
    logic [DATA_SIZE-1:0] dout;

    int in_q[$];
    int exp_q[$];
    int obs_q[$];
    int pop_cycles[$];
    int push_cycles[$];
    int cycle      = 0;
    int checks     = 0;
    int errors     = 0;
    int push_count = 0;
    int m_xp       = 0;
    int m_yp       = 0;
    bit force_full = 1'b0;
    bit rand_empty = 1'b0;
    bit rand_full  = 1'b0;

    iir_deemph dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .din       (din),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .dout      (dout)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Reference filter: SV integer division already truncates toward zero.
    function automatic longint dq(input longint p);
        return p / (longint'(1) << BITS);
    endfunction

    function automatic int model_next(input int x);
        longint sum;
        int     y;
        sum  = dq(longint'(X0) * x) + dq(longint'(X1) * m_xp) - dq(longint'(Y1) * m_yp);
        y    = int'(sum);
        m_xp = x;
        m_yp = y;
        return y;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input bit use_lit, input int lit);
        int y;
        y = model_next(x);
        in_q.push_back(x);
        exp_q.push_back(use_lit ? lit : y);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        in_q.delete();
        exp_q.delete();
        pop_cycles.delete();
        push_cycles.delete();
        m_xp = 0;
        m_yp = 0;
        #1;
        checkOutput("reset_dout", $signed(dout), 0);
        checkOutput("reset_wr_en", out_wr_en, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_in_level(input int level, input int budget);
        int n = 0;
        while (in_q.size() > level && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("pop_wait_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clock);
            n++;
        end
        checkOutput("drain_timeout", (n >= budget) ? 1 : 0, 0);
        repeat (3) @(posedge clock);
    endtask

    // Input FIFO model: show-ahead head on din, optional random emptiness and output back-pressure.
    initial begin
        bit pop_now;
        int pop_at;
        forever begin
            @(negedge clock);
            in_empty = (in_q.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
            din      = (in_q.size() != 0) ? in_q[0] : 0;
            out_full = force_full || (rand_full && $urandom_range(0, 2) == 0);
            #1;
            pop_now = in_rd_en && !in_empty;
            pop_at  = cycle;
            @(posedge clock);
            if (pop_now && reset) begin
                void'(in_q.pop_front());
                pop_cycles.push_back(pop_at);
            end
        end
    end

    // Monitor: every push the DUT is about to make is compared with the scoreboard head.
    initial forever begin
        @(negedge clock);
        #2;
        if (reset && out_wr_en && !out_full) begin
            push_count++;
            push_cycles.push_back(cycle);
            obs_q.push_back(int'($signed(dout)));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_push: got %0d, expected no push", $signed(dout));
            end else begin
                checkOutput("dout", $signed(dout), exp_q.pop_front());
            end
        end
    end

    initial begin
        int base;
        int nonmono;
        int x;

        applyStimulus(1024, 1'b1, 178);
        applyStimulus(0, 1'b1, 293);
        applyStimulus(0, 1'b1, 190);
        @(negedge clock);
        #1;
        checkOutput("reset_dout", $signed(dout), 0);
        checkOutput("reset_rd_en", in_rd_en, 0);
        checkOutput("reset_wr_en", out_wr_en, 0);
        @(negedge clock);
        reset = 1'b1;
        drain(200);
        checkOutput("impulse_pushes", push_cycles.size(), 3);
        if (push_cycles.size() >= 3 && pop_cycles.size() >= 1) begin
            checkOutput("latency", push_cycles[0] - pop_cycles[0], 4);
            checkOutput("interval_1", push_cycles[1] - push_cycles[0], 5);
            checkOutput("interval_2", push_cycles[2] - push_cycles[1], 5);
        end

        do_reset();
        applyStimulus(3, 1'b1, 0);
        drain(100);
        do_reset();
        applyStimulus(-3, 1'b1, 0);
        drain(100);
        do_reset();
        applyStimulus(-1024, 1'b1, -178);
        drain(100);

        do_reset();
        applyStimulus(1024, 1'b1, 178);
        drain(100);
        force_full = 1'b1;
        applyStimulus(2000, 1'b0, 0);
        applyStimulus(-500, 1'b0, 0);
        base = push_count;
        wait_in_level(1, 100);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            checkOutput("stall_wr_en", out_wr_en, 0);
            checkOutput("stall_rd_en", in_rd_en, 0);
            checkOutput("stall_dout", $signed(dout), exp_q[0]);
        end
        force_full = 1'b0;
        drain(200);
        checkOutput("stall_push_count", push_count - base, 2);

        do_reset();
        rand_empty = 1'b1;
        rand_full  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            x = ($urandom_range(0, 1) == 0) ? int'($urandom)
                                            : int'($urandom_range(0, 40000)) - 20000;
            applyStimulus(x, 1'b0, 0);
        end
        drain(3000);
        rand_empty = 1'b0;
        rand_full  = 1'b0;

        applyStimulus(5000, 1'b0, 0);
        drain(100);
        applyStimulus(777, 1'b0, 0);
        wait_in_level(0, 100);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_dout", $signed(dout), 0);
        checkOutput("async_rd_en", in_rd_en, 0);
        checkOutput("async_wr_en", out_wr_en, 0);
        exp_q.delete();
        in_q.delete();
        m_xp = 0;
        m_yp = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        applyStimulus(1024, 1'b1, 178);
        drain(100);

        // Truncation leaves the settled step a few LSBs under unity.
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1024, 1'b0, 0);
        end
        drain(1000);
        nonmono = 0;
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i] < obs_q[i-1]) nonmono++;
        end
        checkOutput("step_count", obs_q.size(), 64);
        checkOutput("step_monotonic", nonmono, 0);
        if (obs_q.size() != 0) begin
            checkOutput("step_settle", (obs_q[obs_q.size()-1] >= 1016 && obs_q[obs_q.size()-1] <= 1032) ? 1 : 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
